// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller for the 5-stage MIPS pipeline: load-use and no-forward RAW
// stalls, branch flush sequencing, data-memory wait freeze and a stall-cycle counter.
module hazard_stall_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 255,
  parameter int REG_ADDR_W   = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] src1_ID,
  input  logic [REG_ADDR_W-1:0] src2_ID,
  input  logic                  two_src_ID,
  input  logic [REG_ADDR_W-1:0] dest_EXE,
  input  logic                  wb_en_EXE,
  input  logic                  mem_r_en_EXE,
  input  logic [REG_ADDR_W-1:0] dest_MEM,
  input  logic                  wb_en_MEM,
  input  logic                  fwd_en,
  input  logic                  branch_taken,
  input  logic                  dmem_req,
  input  logic                  dmem_ready,
  output logic                  freeze_pc,
  output logic                  freeze_IF_ID,
  output logic                  bubble_ID_EXE,
  output logic                  flush_IF_ID,
  output logic                  freeze_all,
  output logic                  timeout_err,
  output logic [15:0]           stall_cnt
);

  typedef enum logic [1:0] {RUN, FLUSH, MEM_WAIT} state_t;

  localparam logic [1:0]  FLUSH_INIT = 2'(FLUSH_CYCLES - 1);
  localparam logic [15:0] WAIT_LAST  = 16'(MEM_TIMEOUT - 1);

  state_t      state;
  logic [1:0]  flush_cnt;
  logic [15:0] wait_cnt;

  logic hz_exe, hz_mem, data_hz, mem_stall, mem_tmo;
  logic hold_front, hold_back, bubble, flush;

  assign hz_exe = wb_en_EXE && (dest_EXE != '0) &&
                  ((src1_ID == dest_EXE) || (two_src_ID && (src2_ID == dest_EXE)));
  assign hz_mem = wb_en_MEM && (dest_MEM != '0) &&
                  ((src1_ID == dest_MEM) || (two_src_ID && (src2_ID == dest_MEM)));
  // With forwarding only a load in EXE is uncoverable; without it any pending writer is.
  assign data_hz   = fwd_en ? (hz_exe && mem_r_en_EXE) : (hz_exe || hz_mem);
  assign mem_stall = dmem_req && !dmem_ready;
  // The cycle whose increment would reach the limit gives up instead of freezing.
  assign mem_tmo   = (state == MEM_WAIT) && !dmem_ready && (wait_cnt == WAIT_LAST);

  always_comb begin
    hold_front = 1'b0;
    hold_back  = 1'b0;
    bubble     = 1'b0;
    flush      = 1'b0;
    unique case (state)
      RUN: begin
        if (mem_stall) begin
          hold_front = 1'b1;
          hold_back  = 1'b1;
        end else if (branch_taken) begin
          flush  = 1'b1;
          bubble = 1'b1;
        end else if (data_hz) begin
          hold_front = 1'b1;
          bubble     = 1'b1;
        end
      end
      FLUSH: begin
        if (mem_stall) begin
          hold_front = 1'b1;
          hold_back  = 1'b1;
        end else begin
          flush  = 1'b1;
          bubble = 1'b1;
        end
      end
      MEM_WAIT: begin
        hold_front = !dmem_ready && !mem_tmo;
        hold_back  = !dmem_ready && !mem_tmo;
      end
      default: ;
    endcase
  end

  assign freeze_pc     = !rst && hold_front;
  assign freeze_IF_ID  = !rst && hold_front;
  assign freeze_all    = !rst && hold_back;
  assign bubble_ID_EXE = !rst && bubble;
  assign flush_IF_ID   = !rst && flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      flush_cnt   <= '0;
      wait_cnt    <= '0;
      stall_cnt   <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (freeze_pc && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
      unique case (state)
        RUN: begin
          if (mem_stall) begin
            state    <= MEM_WAIT;
            wait_cnt <= 16'd1;
          end else if (branch_taken && (FLUSH_CYCLES > 1)) begin
            state     <= FLUSH;
            flush_cnt <= FLUSH_INIT;
          end
        end
        FLUSH: begin
          // flush_cnt is held across a memory wait so the flush resumes afterwards.
          if (mem_stall) begin
            state    <= MEM_WAIT;
            wait_cnt <= 16'd1;
          end else begin
            flush_cnt <= flush_cnt - 2'd1;
            if (flush_cnt == 2'd1)
              state <= RUN;
          end
        end
        MEM_WAIT: begin
          if (dmem_ready || mem_tmo) begin
            wait_cnt <= '0;
            state    <= (flush_cnt != 2'd0) ? FLUSH : RUN;
            if (mem_tmo)
              timeout_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl (FLUSH_CYCLES=2, MEM_TIMEOUT=8).
module tb_hazard_stall_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] src1_ID, src2_ID, dest_EXE, dest_MEM;
  logic       two_src_ID, wb_en_EXE, mem_r_en_EXE, wb_en_MEM, fwd_en;
  logic       branch_taken, dmem_req, dmem_ready;
  logic       freeze_pc, freeze_IF_ID, bubble_ID_EXE, flush_IF_ID, freeze_all, timeout_err;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  // Control vector order: freeze_pc, freeze_IF_ID, bubble_ID_EXE, flush_IF_ID, freeze_all
  localparam logic [4:0] C_NONE  = 5'b00000;
  localparam logic [4:0] C_STALL = 5'b11100;
  localparam logic [4:0] C_FLUSH = 5'b00110;
  localparam logic [4:0] C_FRZ   = 5'b11001;

  hazard_stall_ctrl #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(8), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .src1_ID(src1_ID), .src2_ID(src2_ID), .two_src_ID(two_src_ID),
    .dest_EXE(dest_EXE), .wb_en_EXE(wb_en_EXE), .mem_r_en_EXE(mem_r_en_EXE),
    .dest_MEM(dest_MEM), .wb_en_MEM(wb_en_MEM), .fwd_en(fwd_en),
    .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .freeze_pc(freeze_pc), .freeze_IF_ID(freeze_IF_ID), .bubble_ID_EXE(bubble_ID_EXE),
    .flush_IF_ID(flush_IF_ID), .freeze_all(freeze_all), .timeout_err(timeout_err),
    .stall_cnt(stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic [4:0] exp);
    chk(tag, {27'd0, freeze_pc, freeze_IF_ID, bubble_ID_EXE, flush_IF_ID, freeze_all}, {27'd0, exp});
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  task automatic clr;
    src1_ID = 0; src2_ID = 0; two_src_ID = 0;
    dest_EXE = 0; wb_en_EXE = 0; mem_r_en_EXE = 0;
    dest_MEM = 0; wb_en_MEM = 0; fwd_en = 1;
    branch_taken = 0; dmem_req = 0; dmem_ready = 0;
  endtask

  task automatic load_use;
    clr();
    dest_EXE = 5; wb_en_EXE = 1; mem_r_en_EXE = 1; src1_ID = 5;
  endtask

  initial begin
    // Reset with a memory stall and a hazard pending: outputs must stay low.
    rst = 1'b1;
    load_use();
    dmem_req = 1;
    nxt(); nxt();
    smp();
    chk_ctl("rst_ctl", C_NONE);
    chk("rst_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("rst_tmo", {31'd0, timeout_err}, 32'd0);
    nxt();
    rst = 1'b0;
    clr();
    smp(); chk_ctl("idle", C_NONE);
    nxt();

    // Load-use with forwarding: one stall cycle.
    load_use();
    smp(); chk_ctl("lu_c1", C_STALL); chk("lu_cnt0", {16'd0, stall_cnt}, 32'd0);
    nxt();
    clr(); dest_MEM = 5; wb_en_MEM = 1; src1_ID = 5;
    smp(); chk_ctl("lu_c2", C_NONE); chk("lu_cnt1", {16'd0, stall_cnt}, 32'd1);
    nxt();

    // No forwarding, src2 read: EXE match then MEM match.
    clr(); fwd_en = 0; dest_EXE = 7; wb_en_EXE = 1; src1_ID = 3; src2_ID = 7; two_src_ID = 1;
    smp(); chk_ctl("nf_exe", C_STALL);
    nxt();
    clr(); fwd_en = 0; dest_MEM = 7; wb_en_MEM = 1; src1_ID = 3; src2_ID = 7; two_src_ID = 1;
    smp(); chk_ctl("nf_mem", C_STALL);
    nxt();
    clr(); fwd_en = 0; src1_ID = 3; src2_ID = 7; two_src_ID = 1;
    smp(); chk_ctl("nf_done", C_NONE); chk("nf_cnt", {16'd0, stall_cnt}, 32'd3);
    nxt();
    clr(); fwd_en = 0; dest_EXE = 7; wb_en_EXE = 1; src1_ID = 3; src2_ID = 7; two_src_ID = 0;
    smp(); chk_ctl("nf_one_src", C_NONE);
    nxt();
    clr(); fwd_en = 0; dest_EXE = 0; wb_en_EXE = 1; dest_MEM = 0; wb_en_MEM = 1; two_src_ID = 1;
    smp(); chk_ctl("nf_r0", C_NONE);
    nxt();

    // Branch coincident with load-use: two flush cycles, no freeze.
    load_use(); branch_taken = 1;
    smp(); chk_ctl("br_c1", C_FLUSH);
    nxt();
    load_use();
    smp(); chk_ctl("br_c2", C_FLUSH);
    nxt();
    clr();
    smp(); chk_ctl("br_done", C_NONE); chk("br_cnt", {16'd0, stall_cnt}, 32'd3);
    nxt();

    // Memory wait interrupting a flush; flush resumes after ready.
    clr(); branch_taken = 1;
    smp(); chk_ctl("mw_br", C_FLUSH);
    nxt();
    for (int i = 0; i < 4; i++) begin
      clr(); dmem_req = 1;
      smp(); chk_ctl($sformatf("mw_frz%0d", i), C_FRZ);
      nxt();
    end
    clr(); dmem_req = 1; dmem_ready = 1;
    smp(); chk_ctl("mw_ready", C_NONE);
    nxt();
    clr();
    smp(); chk_ctl("mw_resume", C_FLUSH);
    nxt();
    smp(); chk_ctl("mw_done", C_NONE); chk("mw_cnt", {16'd0, stall_cnt}, 32'd7);
    nxt();
    clr(); dmem_req = 1; dmem_ready = 1;
    smp(); chk_ctl("mw_sameready", C_NONE);
    nxt();

    // Timeout: 7 frozen cycles, release on the 8th, sticky error.
    for (int i = 0; i < 7; i++) begin
      clr(); dmem_req = 1;
      smp(); chk_ctl($sformatf("to_frz%0d", i), C_FRZ);
      chk($sformatf("to_err%0d", i), {31'd0, timeout_err}, 32'd0);
      nxt();
    end
    clr();
    smp(); chk_ctl("to_release", C_NONE); chk("to_err7", {31'd0, timeout_err}, 32'd0);
    nxt();
    smp(); chk("to_err_set", {31'd0, timeout_err}, 32'd1); chk_ctl("to_run", C_NONE);
    chk("to_cnt", {16'd0, stall_cnt}, 32'd14);
    nxt();
    smp(); chk("to_sticky", {31'd0, timeout_err}, 32'd1);

    // Reset clears counter and error, forces outputs low.
    nxt();
    rst = 1'b1; load_use();
    smp(); chk_ctl("rst2_ctl", C_NONE);
    nxt();
    smp(); chk("rst2_cnt", {16'd0, stall_cnt}, 32'd0); chk("rst2_tmo", {31'd0, timeout_err}, 32'd0);
    chk_ctl("rst2_ctl_b", C_NONE);
    nxt();
    rst = 1'b0;

    // Counter saturation over 65540 stall cycles.
    load_use();
    repeat (65535) nxt();
    smp(); chk("sat_max", {16'd0, stall_cnt}, 32'hFFFF);
    nxt();
    repeat (4) nxt();
    smp(); chk("sat_hold", {16'd0, stall_cnt}, 32'hFFFF); chk_ctl("sat_ctl", C_STALL);
    nxt();
    clr();
    smp(); chk_ctl("sat_end", C_NONE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
